// File: rtl/cla_seq_adder_if.sv
// Handshake and operand/result bundle for the sequential carry-lookahead adder.
// The bench drives the master side; the adder is the slave.
interface cla_seq_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract built from one 4-bit carry-lookahead slice,
// processing one nibble per clock, LSB first, with a start/busy/done handshake.
module cla_seq_adder #(
  parameter int NIBBLES = 4
) (
  input logic            clk,
  input logic            rst_n,
  cla_seq_adder_if.slave bus
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, work_q, sum_q;
  logic             cout_q, ovf_q;

  logic             accept, last;
  logic [3:0]       a_nib [NIBBLES];
  logic [3:0]       b_nib [NIBBLES];
  logic [3:0]       nib_a, nib_b, nib_g, nib_p, nib_s;
  logic [4:0]       nib_c;
  logic [WIDTH-1:0] full_res;

  // Splice the current slice output into the working word at the active nibble.
  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_q[gi*4 +: 4];
      assign b_nib[gi] = b_q[gi*4 +: 4];
      assign full_res[gi*4 +: 4] = (idx_q == IDXW'(gi)) ? nib_s : work_q[gi*4 +: 4];
    end
  endgenerate

  assign nib_a = a_nib[idx_q];
  assign nib_b = b_nib[idx_q];
  assign nib_g = nib_a & nib_b;
  assign nib_p = nib_a ^ nib_b;

  assign nib_c[0] = carry_q;
  assign nib_c[1] = nib_g[0] | (nib_p[0] & carry_q);
  assign nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & carry_q);
  assign nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
                  | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
  assign nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
                  | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                  | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
  assign nib_s    = nib_p ^ nib_c[3:0];

  assign last   = (idx_q == IDXW'(NIBBLES - 1));
  assign accept = (state_q != RUN) && bus.start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.sub ? ~bus.b : bus.b;
        carry_q <= bus.sub ? 1'b1 : bus.cin;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        work_q  <= full_res;
        carry_q <= nib_c[4];
        if (!last) begin
          idx_q <= idx_q + 1'b1;
        end else begin
          // Results are only published here, so they hold through the next RUN.
          sum_q  <= full_res;
          cout_q <= nib_c[4];
          ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full_res[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule
